vc_tx_arbiter: RTL

Schedules the two virtual-channel FIFOs (VC0 high priority, VC1 low priority) of the PCIe transmission layer onto one downstream FIFO. Issues rd_enable (pop) to the VC FIFOs and push to the downstream FIFO, honouring downstream almost-full backpressure. Bounds VC0 bursts so VC1 cannot starve. Also owns threshold (umbral) configuration for all three FIFOs through an INIT phase.

---
 rtl/vc_arb_pkg.sv | 17 +
 rtl/vc_grant_logic.sv | 54 +++++
 rtl/vc_tx_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/vc_arb_pkg.sv
// rtl/vc_arb_pkg.sv - shared encodings and constants for the VC transmit arbiter
package vc_arb_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } arb_state_e;

  localparam int VC0 = 0;
  localparam int VC1 = 1;

  localparam int UMBRAL_MIN_VC  = 1;
  localparam int UMBRAL_MIN_DST = 2;

endpackage

// File: rtl/vc_grant_logic.sv
// rtl/vc_grant_logic.sv - VC eligibility, priority with bounded VC0 bursts, burst counter
module vc_grant_logic
  import vc_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       empty_vc0_i,
  input  logic       empty_vc1_i,
  input  logic       almost_empty_vc0_i,
  input  logic       almost_empty_vc1_i,
  input  logic       pop_vc0_i,
  input  logic       pop_vc1_i,
  output logic [1:0] grant_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] burst_q, burst_d;
  logic          elig_vc0, elig_vc1, burst_full, pick_vc1;

  // A pop in flight has not yet reached the FIFO count, so a nearly drained VC
  // must skip a cycle rather than risk popping an empty FIFO.
  assign elig_vc0   = !empty_vc0_i && (!pop_vc0_i || !almost_empty_vc0_i);
  assign elig_vc1   = !empty_vc1_i && (!pop_vc1_i || !almost_empty_vc1_i);
  assign burst_full = (burst_q == CW'(MAX_BURST));
  assign pick_vc1   = elig_vc1 && (!elig_vc0 || burst_full);

  always_comb begin
    grant_o      = '0;
    grant_o[VC1] = en_i && pick_vc1;
    grant_o[VC0] = en_i && elig_vc0 && !pick_vc1;
  end

  always_comb begin
    burst_d = burst_q;
    if (empty_vc1_i || grant_o[VC1]) begin
      burst_d = '0;
    end else if (grant_o[VC0] && !burst_full) begin
      burst_d = burst_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/vc_tx_arbiter.sv
// rtl/vc_tx_arbiter.sv - schedules VC0/VC1 FIFOs onto the downstream FIFO and owns FIFO thresholds
module vc_tx_arbiter
  import vc_arb_pkg::*;
#(
  parameter int data_width   = 6,
  parameter int MAX_BURST    = 4,
  parameter int umbral_width = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [umbral_width-1:0] umbral_vc0_in,
  input  logic [umbral_width-1:0] umbral_vc1_in,
  input  logic [umbral_width-1:0] umbral_dst_in,
  input  logic                    empty_vc0,
  input  logic                    empty_vc1,
  input  logic                    almost_empty_vc0,
  input  logic                    almost_empty_vc1,
  input  logic [data_width-1:0]   data_vc0,
  input  logic [data_width-1:0]   data_vc1,
  input  logic                    dst_almost_full,
  output logic                    pop_vc0,
  output logic                    pop_vc1,
  output logic                    push_out,
  output logic [data_width-1:0]   data_out,
  output logic [umbral_width-1:0] umbral_vc0,
  output logic [umbral_width-1:0] umbral_vc1,
  output logic [umbral_width-1:0] umbral_dst,
  output logic [1:0]              state,
  output logic                    idle_out
);

  localparam logic [umbral_width-1:0] MIN_VC  = umbral_width'(UMBRAL_MIN_VC);
  localparam logic [umbral_width-1:0] MIN_DST = umbral_width'(UMBRAL_MIN_DST);

  arb_state_e              state_q, state_d;
  logic                    pop_vc0_q, pop_vc1_q, push_q, idle_q;
  logic [data_width-1:0]   data_q;
  logic [umbral_width-1:0] umbral_vc0_q, umbral_vc1_q, umbral_dst_q;
  logic [1:0]              tag_vld_q, tag_vc_q;
  logic [1:0]              grant;
  logic                    grant_en;

  assign grant_en = (state_q == ST_ACTIVE) && !init && !dst_almost_full;

  vc_grant_logic #(
    .MAX_BURST(MAX_BURST)
  ) u_grant (
    .clk_i             (clk),
    .rst_ni            (reset),
    .en_i              (grant_en),
    .empty_vc0_i       (empty_vc0),
    .empty_vc1_i       (empty_vc1),
    .almost_empty_vc0_i(almost_empty_vc0),
    .almost_empty_vc1_i(almost_empty_vc1),
    .pop_vc0_i         (pop_vc0_q),
    .pop_vc1_i         (pop_vc1_q),
    .grant_o           (grant)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init) state_d = ST_INIT;
        else if (!empty_vc0 || !empty_vc1) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init) state_d = ST_INIT;
        else if (empty_vc0 && empty_vc1 && (tag_vld_q == 2'b00)) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      pop_vc0_q    <= 1'b0;
      pop_vc1_q    <= 1'b0;
      push_q       <= 1'b0;
      data_q       <= '0;
      idle_q       <= 1'b0;
      umbral_vc0_q <= '0;
      umbral_vc1_q <= '0;
      umbral_dst_q <= '0;
      tag_vld_q    <= '0;
      tag_vc_q     <= '0;
    end else begin
      state_q   <= state_d;
      idle_q    <= (state_d == ST_IDLE);
      pop_vc0_q <= grant[VC0];
      pop_vc1_q <= grant[VC1];
      // Stage 0 mirrors the pop cycle, stage 1 is the cycle the FIFO presents data.
      tag_vld_q <= {tag_vld_q[0], |grant};
      tag_vc_q  <= {tag_vc_q[0], grant[VC1]};
      push_q    <= tag_vld_q[1];
      data_q    <= !tag_vld_q[1] ? '0 : (tag_vc_q[1] ? data_vc1 : data_vc0);
      if (state_q == ST_INIT) begin
        umbral_vc0_q <= (umbral_vc0_in < MIN_VC)  ? MIN_VC  : umbral_vc0_in;
        umbral_vc1_q <= (umbral_vc1_in < MIN_VC)  ? MIN_VC  : umbral_vc1_in;
        umbral_dst_q <= (umbral_dst_in < MIN_DST) ? MIN_DST : umbral_dst_in;
      end
    end
  end

  assign pop_vc0    = pop_vc0_q;
  assign pop_vc1    = pop_vc1_q;
  assign push_out   = push_q;
  assign data_out   = data_q;
  assign umbral_vc0 = umbral_vc0_q;
  assign umbral_vc1 = umbral_vc1_q;
  assign umbral_dst = umbral_dst_q;
  assign state      = state_q;
  assign idle_out   = idle_q;

endmodule
